// File: rtl/synth_wr_pkg.sv
// Shared types and constants for the synth register writer.
// Holds the write FSM state encoding, requester IDs and default bus widths.
// No logic; imported by synth_reg_writer and rr_arb2.
package synth_wr_pkg;

    localparam int DEF_ADDR_BITS = 4;
    localparam int DEF_DATA_BITS = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } wr_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/synth_reg_writer_rr_arb2.sv
// Purpose: 2-way round-robin arbiter; grants only a valid requester, alternates on contention.
// Latency: grant is combinational from valid/enable; priority pointer updates on the accept edge.
// Backpressure: no grant while enable is low; pointer holds until a grant is actually accepted.
module rr_arb2
    import synth_wr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_enable,
    input  logic       i_accept,
    output logic [1:0] o_grant,
    output logic       o_last_id
);

    logic r_prio_b;   // 1: B wins the next contended cycle
    logic r_last_id;  // requester of the most recent accepted grant

    // One-hot grant: single valid requester always wins, contention resolved by pointer
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            if (i_valid == 2'b11) begin
                o_grant = r_prio_b ? 2'b10 : 2'b01;
            end else begin
                o_grant = i_valid;
            end
        end
    end

    // Pointer moves away from whoever was just accepted; reset favours A
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prio_b  <= 1'b0;
            r_last_id <= REQ_A;
        end else if (i_accept && (o_grant != 2'b00)) begin
            r_last_id <= o_grant[1];
            r_prio_b  <= ~o_grant[1];
        end
    end

    assign o_last_id = r_last_id;

endmodule

// File: rtl/synth_reg_writer.sv
// Purpose: arbitrates two requesters onto the synth strobed register port with setup/strobe/gap timing.
// Latency: accept at E0 -> addr/data valid after E0, strobe high E1..E1+STROBE_CYCLES; period 2+STROBE+GAP.
// Backpressure: both readies low outside IDLE; optional SYNTH_WR_SHADOW_EN drops redundant writes.
module synth_reg_writer
    import synth_wr_pkg::*;
#(
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int STROBE_CYCLES = 1,
    parameter int GAP_CYCLES    = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid_i,
    output logic                 a_ready_o,
    input  logic [ADDR_BITS-1:0] a_addr_i,
    input  logic [DATA_BITS-1:0] a_data_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,
    input  logic [ADDR_BITS-1:0] b_addr_i,
    input  logic [DATA_BITS-1:0] b_data_i,
    output logic [ADDR_BITS-1:0] syn_addr_o,
    output logic [DATA_BITS-1:0] syn_data_o,
    output logic                 syn_strobe_o,
    output logic                 busy_o,
    output logic                 grant_o
`ifdef SYNTH_WR_SHADOW_EN
    ,
    output logic                 dropped_o
`endif
);

    // One counter serves both timed states, so size it for the longer of the two
    localparam int CNT_MAX = max2(STROBE_CYCLES, GAP_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STB_LOAD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    wr_state_t            r_state;
    wr_state_t            w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;

    logic [1:0]           w_grant;
    logic                 w_last_id;
    logic                 w_enable;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_take;
    logic [ADDR_BITS-1:0] w_win_addr;
    logic [DATA_BITS-1:0] w_win_data;

    // Readies are gated by reset so nothing is offered while the block is held in reset
    assign w_enable = rst_n && (r_state == IDLE);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   ({b_valid_i, a_valid_i}),
        .i_enable  (w_enable),
        .i_accept  (w_accept),
        .o_grant   (w_grant),
        .o_last_id (w_last_id)
    );

    assign a_ready_o  = w_grant[0];
    assign b_ready_o  = w_grant[1];
    assign w_accept   = |(w_grant & {b_valid_i, a_valid_i});
    assign w_win_addr = w_grant[1] ? b_addr_i : a_addr_i;
    assign w_win_data = w_grant[1] ? b_data_i : a_data_i;
    assign grant_o    = w_last_id;

`ifdef SYNTH_WR_SHADOW_EN
    logic [DATA_BITS-1:0]    r_shadow [2**ADDR_BITS];
    logic [2**ADDR_BITS-1:0] r_shadow_vld;
    logic                    r_dropped;

    // A write that would not change the synth register is consumed without a bus cycle
    assign w_drop = w_accept && r_shadow_vld[w_win_addr] && (r_shadow[w_win_addr] == w_win_data);

    // Shadow data commits as the strobe starts; the array itself needs no reset
    always_ff @(posedge clk) begin
        if (r_state == SETUP) begin
            r_shadow[syn_addr_o] <= syn_data_o;
        end
    end

    // Valid bits track which shadow entries hold a real written value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow_vld <= '0;
        end else if (r_state == SETUP) begin
            r_shadow_vld[syn_addr_o] <= 1'b1;
        end
    end

    // One-cycle pulse following each dropped write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_accept && w_drop;
        end
    end

    assign dropped_o = r_dropped;
`else
    assign w_drop = 1'b0;
`endif

    assign w_take = w_accept && !w_drop;

    // State register; reset abandons any in-flight write immediately
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe/busy decode
    always_comb begin
        w_state_nxt  = r_state;
        syn_strobe_o = 1'b0;
        busy_o       = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = STROBE;
            end
            STROBE: begin
                syn_strobe_o = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shared down-counter: loaded on entry to STROBE and HOLD, stops at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_cnt <= STB_LOAD;
        end else if ((r_state == STROBE) && (r_cnt == '0)) begin
            r_cnt <= GAP_LOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Address/data latch only at a bus-generating accept and stay put until the next one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            syn_addr_o <= '0;
            syn_data_o <= '0;
        end else if (w_take) begin
            syn_addr_o <= w_win_addr;
            syn_data_o <= w_win_data;
        end
    end

endmodule

// File: tb/tb_synth_reg_writer.sv
// Bench for synth_reg_writer: default instance plus a STROBE=3/GAP=0 instance.
// Scoreboard queues are filled at stimulus time and drained at each strobe rising edge.
// Optional SYNTH_WR_SHADOW_EN section exercises redundant-write dropping.
`timescale 1ns/1ps
module tb_synth_reg_writer;
    import synth_wr_pkg::*;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic       id;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // default instance
    logic       a_vld, b_vld, a_rdy, b_rdy, stb, busy, gnt;
    logic [3:0] a_addr, b_addr, s_addr;
    logic [7:0] a_dat, b_dat, s_dat;
`ifdef SYNTH_WR_SHADOW_EN
    logic       dropped;
`endif

    // STROBE_CYCLES=3, GAP_CYCLES=0 instance
    logic       ca_vld, cb_vld, ca_rdy, cb_rdy, c_stb, c_busy, c_gnt;
    logic [3:0] ca_addr, cb_addr, c_saddr;
    logic [7:0] ca_dat, cb_dat, c_sdat;

    synth_reg_writer u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(a_vld), .a_ready_o(a_rdy), .a_addr_i(a_addr), .a_data_i(a_dat),
        .b_valid_i(b_vld), .b_ready_o(b_rdy), .b_addr_i(b_addr), .b_data_i(b_dat),
        .syn_addr_o(s_addr), .syn_data_o(s_dat), .syn_strobe_o(stb),
        .busy_o(busy), .grant_o(gnt)
`ifdef SYNTH_WR_SHADOW_EN
        , .dropped_o(dropped)
`endif
    );

    synth_reg_writer #(.STROBE_CYCLES(3), .GAP_CYCLES(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(ca_vld), .a_ready_o(ca_rdy), .a_addr_i(ca_addr), .a_data_i(ca_dat),
        .b_valid_i(cb_vld), .b_ready_o(cb_rdy), .b_addr_i(cb_addr), .b_data_i(cb_dat),
        .syn_addr_o(c_saddr), .syn_data_o(c_sdat), .syn_strobe_o(c_stb),
        .busy_o(c_busy), .grant_o(c_gnt)
`ifdef SYNTH_WR_SHADOW_EN
        , .dropped_o()
`endif
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    int rise0[$];
    int rise1[$];
    logic p0 = 1'b0, p1 = 1'b0;
    int w0 = 0, w1 = 0;
    exp_t m0, m1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard for default instance
    always @(negedge clk) begin
        if (!rst_n) begin
            p0 = 1'b0; w0 = 0;
        end else begin
            if (stb && !p0) begin
                rise0.push_back(cyc);
                chk("sb0_strobe_expected", 32'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    m0 = q0.pop_front();
                    chk("sb0_addr", 32'(s_addr), 32'(m0.addr));
                    chk("sb0_data", 32'(s_dat), 32'(m0.data));
                    chk("sb0_grant", 32'(gnt), 32'(m0.id));
                end
                w0 = 1;
            end else if (stb) begin
                w0++;
            end else if (p0) begin
                chk("sb0_strobe_width", w0, 1);
            end
            p0 = stb;
        end
    end

    // scoreboard for STROBE=3/GAP=0 instance
    always @(negedge clk) begin
        if (!rst_n) begin
            p1 = 1'b0; w1 = 0;
        end else begin
            if (c_stb && !p1) begin
                rise1.push_back(cyc);
                chk("sb1_strobe_expected", 32'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    m1 = q1.pop_front();
                    chk("sb1_addr", 32'(c_saddr), 32'(m1.addr));
                    chk("sb1_data", 32'(c_sdat), 32'(m1.data));
                    chk("sb1_grant", 32'(c_gnt), 32'(m1.id));
                end
                w1 = 1;
            end else if (c_stb) begin
                w1++;
            end else if (p1) begin
                chk("sb1_strobe_width", w1, 3);
            end
            p1 = c_stb;
        end
    end

    task automatic drive(input bit sel, input logic req, input logic v,
                         input logic [3:0] ad, input logic [7:0] dt);
        case ({sel, req})
            2'b00: begin a_vld = v; a_addr = ad; a_dat = dt; end
            2'b01: begin b_vld = v; b_addr = ad; b_dat = dt; end
            2'b10: begin ca_vld = v; ca_addr = ad; ca_dat = dt; end
            default: begin cb_vld = v; cb_addr = ad; cb_dat = dt; end
        endcase
    endtask

    task automatic push_exp(input bit sel, input logic req, input logic [3:0] ad, input logic [7:0] dt);
        exp_t e;
        e.addr = ad; e.data = dt; e.id = req;
        if (sel) q1.push_back(e);
        else q0.push_back(e);
    endtask

    // present one write and hold it until accepted; returns cycles spent waiting for ready
    task automatic send(input bit sel, input logic req, input logic [3:0] ad, input logic [7:0] dt,
                        input bit push, output int waited);
        logic rdy;
        @(posedge clk); #1;
        drive(sel, req, 1'b1, ad, dt);
        if (push) push_exp(sel, req, ad, dt);
        waited = -1;
        rdy = 1'b0;
        while (!rdy && waited < 100) begin
            @(negedge clk);
            waited++;
            rdy = sel ? (req ? cb_rdy : ca_rdy) : (req ? b_rdy : a_rdy);
        end
        if (!rdy) chk("send_ready_timeout", waited, 0);
        @(posedge clk); #1;
        drive(sel, req, 1'b0, ad, dt);
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
            done = sel ? (q1.size() == 0 && !c_busy) : (q0.size() == 0 && !busy);
        end
        chk(tag, 32'(done), 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, n_acc, first, bcnt, scnt;
        logic seen;
        rst_n = 1'b0;
        drive(0, REQ_A, 1'b1, 4'd1, 8'h11); drive(0, REQ_B, 1'b1, 4'd2, 8'h22);
        drive(1, REQ_A, 1'b0, 4'd0, 8'h00); drive(1, REQ_B, 1'b0, 4'd0, 8'h00);

        // reset values with both requesters valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 32'(a_rdy), 0);
        chk("rst_b_ready", 32'(b_rdy), 0);
        chk("rst_strobe", 32'(stb), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(gnt), 0);
        chk("rst_addr", 32'(s_addr), 0);
        chk("rst_data", 32'(s_dat), 0);
        drive(0, REQ_A, 1'b0, 4'd0, 8'h00); drive(0, REQ_B, 1'b0, 4'd0, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;

        // single write from A, timing profile
        send(0, REQ_A, 4'd3, 8'hA5, 1'b1, w);
        chk("t1_ready_in_idle", w, 0);
        first = -1; bcnt = 0; scnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("t1_addr_after_e0", 32'(s_addr), 3);
                chk("t1_data_after_e0", 32'(s_dat), 32'h A5);
            end
            if (busy) bcnt++;
            if (stb) scnt++;
            if (stb && first < 0) first = i;
        end
        chk("t1_busy_cycles", bcnt, 11);
        chk("t1_strobe_at_e1", first, 1);
        chk("t1_strobe_cycles", scnt, 1);

        // both valid continuously: A,B,A,B at 12-cycle period
        do_reset();
        rise0.delete();
        @(posedge clk); #1;
        drive(0, REQ_A, 1'b1, 4'd1, 8'h11); drive(0, REQ_B, 1'b1, 4'd2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_exp(0, REQ_A, 4'd1, 8'h11);
            else push_exp(0, REQ_B, 4'd2, 8'h22);
        end
        n_acc = 0; n = 0;
        while (n_acc < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (a_rdy || b_rdy) begin
                chk("t2_grant_order", 32'(b_rdy), n_acc % 2);
                n_acc++;
            end
        end
        @(posedge clk); #1;
        drive(0, REQ_A, 1'b0, 4'd0, 8'h00); drive(0, REQ_B, 1'b0, 4'd0, 8'h00);
        wait_done(0, "t2_done");
        chk("t2_write_count", rise0.size(), 4);
        for (int i = 1; i < 4; i++)
            if (i < rise0.size()) chk("t2_period", rise0[i] - rise0[i-1], 12);

        // STROBE=3, GAP=0: three back-to-back writes, 5-cycle period
        rise1.delete();
        @(posedge clk); #1;
        drive(1, REQ_A, 1'b1, 4'd7, 8'h3C);
        for (int i = 0; i < 3; i++) push_exp(1, REQ_A, 4'd7, 8'h3C);
        n_acc = 0; n = 0;
        while (n_acc < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (ca_rdy) n_acc++;
        end
        @(posedge clk); #1;
        drive(1, REQ_A, 1'b0, 4'd0, 8'h00);
        wait_done(1, "t3_done");
        chk("t3_write_count", rise1.size(), 3);
        for (int i = 1; i < 3; i++)
            if (i < rise1.size()) chk("t3_period", rise1[i] - rise1[i-1], 5);

        // reset while strobe is high; afterwards A is served first
        send(1, REQ_A, 4'd8, 8'h5A, 1'b1, w);
        n = 0;
        while (!c_stb && n < 50) begin @(negedge clk); n++; end
        chk("t4_strobe_reached", 32'(c_stb), 1);
        #2;
        rst_n = 1'b0;
        drive(1, REQ_A, 1'b1, 4'd1, 8'h11); drive(1, REQ_B, 1'b1, 4'd2, 8'h22);
        @(posedge clk); #1;
        chk("t4_rst_strobe", 32'(c_stb), 0);
        chk("t4_rst_busy", 32'(c_busy), 0);
        chk("t4_rst_addr", 32'(c_saddr), 0);
        chk("t4_rst_data", 32'(c_sdat), 0);
        @(negedge clk);
        chk("t4_rst_a_ready", 32'(ca_rdy), 0);
        chk("t4_rst_b_ready", 32'(cb_rdy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_exp(1, REQ_A, 4'd1, 8'h11);
        @(negedge clk);
        chk("t4_a_first_ready", 32'(ca_rdy), 1);
        chk("t4_b_first_ready", 32'(cb_rdy), 0);
        @(posedge clk); #1;
        drive(1, REQ_A, 1'b0, 4'd0, 8'h00); drive(1, REQ_B, 1'b0, 4'd0, 8'h00);
        wait_done(1, "t4_done");

        // B becomes valid during HOLD and keeps changing its payload until accepted
        send(0, REQ_A, 4'd4, 8'h44, 1'b1, w);
        seen = 1'b0; n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (stb) seen = 1'b1;
            else if (seen) break;
        end
        chk("t5_in_hold", 32'(busy && seen), 1);
        #1;
        drive(0, REQ_B, 1'b1, 4'd6, 8'h01);
        n = 0;
        while (busy && n < 50) begin
            chk("t5_b_ready_hold", 32'(b_rdy), 0);
            chk("t5_data_stable", 32'(s_dat), 32'h44);
            @(posedge clk); #1;
            b_addr = b_addr + 4'd1;
            b_dat = b_dat + 8'd1;
            @(negedge clk);
            n++;
        end
        chk("t5_b_ready_idle", 32'(b_rdy), 1);
        push_exp(0, REQ_B, b_addr, b_dat);
        @(posedge clk); #1;
        drive(0, REQ_B, 1'b0, 4'd0, 8'h00);
        wait_done(0, "t5_done");

`ifdef SYNTH_WR_SHADOW_EN
        // redundant write is dropped, a changed value goes out normally
        send(0, REQ_A, 4'd5, 8'h12, 1'b1, w);
        wait_done(0, "t6_first_done");
        chk("t6_no_drop_first", 32'(dropped), 0);
        send(0, REQ_A, 4'd5, 8'h12, 1'b0, w);
        chk("t6_drop_busy", 32'(busy), 0);
        chk("t6_dropped_pulse", 32'(dropped), 1);
        @(negedge clk);
        chk("t6_dropped_clear", 32'(dropped), 0);
        send(0, REQ_A, 4'd5, 8'h13, 1'b1, w);
        wait_done(0, "t6_third_done");
`endif

        repeat (3) @(posedge clk);
        chk("end_q0_empty", q0.size(), 0);
        chk("end_q1_empty", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/synth_reg_writer.md
Name: synth_reg_writer

Overview:
- Arbitrates register writes from two requesters onto the synth core's strobed register port (data byte, 4-bit address, strobe).
- Requester A is the host/config port; requester B is the song/patch sequencer.
- Enforces address/data setup before strobe, strobe width, and a minimum gap between writes, so neither requester needs to know synth timing.
- Sits directly in front of the synth core's register interface in the FPGA top level.

Parameters:
- ADDR_BITS, 4, synth register address width.
- DATA_BITS, 8, synth register data width.
- STROBE_CYCLES, 1, cycles strobe is held high; legal range is 1 or more.
- GAP_CYCLES, 9, idle cycles after strobe falls before the next write can start; legal range is 0 or more.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- a_valid_i  in  1  requester A write request
- a_ready_o  out  1  requester A accept
- a_addr_i  in  ADDR_BITS  requester A register address
- a_data_i  in  DATA_BITS  requester A write data
- b_valid_i  in  1  requester B write request
- b_ready_o  out  1  requester B accept
- b_addr_i  in  ADDR_BITS  requester B register address
- b_data_i  in  DATA_BITS  requester B write data
- syn_addr_o  out  ADDR_BITS  address to the synth register port
- syn_data_o  out  DATA_BITS  data to the synth register port
- syn_strobe_o  out  1  write strobe to the synth register port
- busy_o  out  1  high whenever the FSM is not in IDLE
- grant_o  out  1  requester of the most recent accepted write (0 = A, 1 = B)

Behaviour:
- Reset: all outputs are 0.
  - FSM state = IDLE.
  - Round-robin pointer favours A first.
  - Reset taking effect mid-write drops syn_strobe_o at that same clock edge; the in-flight write is abandoned and never retried.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - The arbiter drives a_ready_o/b_ready_o combinationally. Ready goes to at most one requester, and only one that is valid.
  - Accept = valid & ready at a rising edge. At accept: capture the winner's addr/data into syn_addr_o/syn_data_o, update grant_o, go to SETUP.
- SETUP: 1 cycle; strobe low. Then go to STROBE.
- STROBE:
  - strobe high for exactly STROBE_CYCLES cycles.
  - Then go to HOLD, or to IDLE if GAP_CYCLES = 0.
- HOLD: strobe low for GAP_CYCLES cycles, then go to IDLE.
- Both ready outputs are 0 in every state except IDLE.
- syn_addr_o/syn_data_o change only at accept; they stay stable through SETUP, STROBE, HOLD and the following IDLE.
- Throughput: one write every 2+STROBE_CYCLES+GAP_CYCLES cycles under continuous demand (12 cycles with defaults).
- Latency: accept at edge E0 gives syn_addr_o/syn_data_o valid after E0 and syn_strobe_o high from E1 to E1+STROBE_CYCLES.
- Arbitration:
  - Only one requester valid: it wins.
  - Both valid: the requester not granted last wins.
  - The pointer updates only on accept.
- Requesters must hold valid, addr and data stable until accepted. The block does not depend on this; it samples only at accept.
- A single shared cycle counter of width clog2(max(STROBE_CYCLES, GAP_CYCLES)+1) runs in STROBE and HOLD. It reloads on each state entry and never wraps.

Optional Feature:
- Macro SYNTH_WR_SHADOW_EN.
- Defined:
  - Keeps a 2^ADDR_BITS x DATA_BITS shadow of last-written values, plus per-address valid bits (cleared on reset).
  - Shadow entry and valid bit update at entry to STROBE.
  - An accepted write whose address has a valid shadow entry equal to its data is consumed with no bus cycle: it stays in IDLE, syn_* outputs are unchanged, the pointer and grant_o still update, and the write can be accepted one cycle later.
  - Adds port dropped_o (1 bit), which pulses for 1 cycle after a dropped write.
- Undefined: every accepted write generates a full bus cycle, and dropped_o does not exist.

Decomposition:
- Package synth_wr_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD);
  - requester ID constants REQ_A = 0 and REQ_B = 1;
  - default ADDR_BITS and DATA_BITS.
- Sub-module rr_arb2: 2-way round-robin arbiter with inputs valid[1:0], enable and accept, and outputs grant one-hot and last_id.

Test Plan:
- A writes addr 3, data 0xA5, B idle, defaults:
  - a_ready_o high in IDLE; syn_addr_o = 3 and syn_data_o = 0xA5 from E0+1;
  - strobe high exactly 1 cycle at E1; busy_o high for 11 cycles; next accept possible at E12.
- A and B both valid continuously with distinct data:
  - grants alternate A, B, A, B, starting with A; one write per 12 cycles; grant_o toggles.
- STROBE_CYCLES = 3, GAP_CYCLES = 0:
  - strobe high 3 consecutive cycles;
  - returns to IDLE directly; period is 5 cycles.
- rst_n low during STROBE:
  - all outputs 0 at that edge;
  - after release, A is first served when both are valid.
- Ready/valid discipline: B valid while the FSM is in HOLD:
  - b_ready_o stays low until IDLE;
  - addr/data changes made by B before accept are ignored; the value present at accept is the one written.
- SYNTH_WR_SHADOW_EN defined: write addr 5 = 0x12 twice:
  - second write produces no strobe and dropped_o pulses once;
  - a following write of addr 5 = 0x13 strobes normally.
